instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory depth in 32-bit words, power of two.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 stall  input  1  consumer cannot accept; freeze fetch.
REQ-006 branch_taken  input  1  redirect to branch target of the currently presented instruction.
REQ-007 branch_offset  input  16  signed word offset of the branch.
REQ-008 jump  input  1  redirect to jump target of the currently presented instruction.
REQ-009 jump_index  input  26  jump instruction index field.
REQ-010 prog_we  input  1  instruction-memory write enable.
REQ-011 prog_addr  input  log2(DEPTH)  instruction-memory word address for writes.
REQ-012 prog_data  input  32  instruction word to write.
REQ-013 In  output  32  fetched instruction to the decode/execute core; 32'h0 (NOP) when not valid.
REQ-014 pc_out  output  32  byte address of the instruction on In.
REQ-015 valid  output  1  In/pc_out hold a real instruction.
REQ-016 halted  output  1  fetch stopped by HALT opcode.

Function
REQ-017 States: IDLE, RUN, HALT; IDLE->RUN on the first edge after reset release, no fetch in IDLE.
REQ-018 Internal pc register; memory word index = pc[log2(DEPTH)+1:2]; higher bits ignored, so index wraps modulo DEPTH.
REQ-019 RUN, stall=0, no redirect: on the edge, In<=imem[index], pc_out<=pc, valid<=1, pc<=pc+4; fetch latency 1 cycle.
REQ-020 pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-021 Stall (any state) has top priority: pc, In, pc_out, valid, state all hold; redirect inputs ignored; consumer holds redirect until stall drops.
REQ-022 Branch target = pc_out + 4 + (sign-extended branch_offset << 2); jump target = {pc_out+4 [31:28], jump_index, 2'b00}.
REQ-023 Redirect only honored when valid=1; on that edge pc<=target, In<=0, valid<=0 (wrong-path fetch squashed); next edge fetches target.
REQ-024 jump and branch_taken together: jump wins.
REQ-025 RUN, valid=1, In[31:26]=6'h3F, stall=0, no redirect: on the edge enter HALT; redirect in the same cycle cancels the halt.
REQ-026 HALT: In=0, valid=0, halted=1, pc frozen; exit only by reset.
REQ-027 prog_we=1 writes imem[prog_addr]<=prog_data on the edge, in any state including stall and HALT.
REQ-028 Write and fetch to the same word in one cycle: fetch returns the old contents (read-first).
REQ-029 Memory contents are not cleared by reset.

Reset
REQ-030 reset=0 immediately (no clock) forces state=IDLE, pc=RESET_PC, In=0, pc_out=RESET_PC, valid=0, halted=0.
REQ-031 Reset asserted mid-stall, mid-redirect or in HALT behaves identically to REQ-030; pending redirect lost.
REQ-032 Reset release is synchronized by the designer's choice of structure such that the first fetch occurs on the second rising edge after release.

Verification
REQ-033 Load imem[0..3]=11111111,22222222,33333333,44444444; release reset -> edge 2: In=11111111, pc_out=0, valid=1; edge 3: 22222222, pc_out=4.
REQ-034 In=imem[1] at pc_out=4, branch_taken=1, branch_offset=16'hFFFF -> next edge valid=0, In=0; following edge In=imem[1], pc_out=4.
REQ-035 pc_out=8, jump=1, jump_index=26'h000_0003, branch_taken=1 -> jump wins; after bubble pc_out=12, In=imem[3].
REQ-036 stall=1 for 3 cycles with In=22222222, pc_out=4, branch_taken pulsed -> outputs unchanged all 3 cycles, branch ignored; stall=0 -> pc_out=8.
REQ-037 imem[2]=FC000000 -> presented at pc_out=8, next edge halted=1, valid=0, In=0; stays until reset=0.
REQ-038 DEPTH=64, fetch at pc=252 -> next fetch pc=256 reads imem[0]; reset=0 mid-run asynchronously clears valid and pc_out=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-issue instruction fetch unit with an on-chip,
// software-loadable instruction memory.
//
// Parameters
//   DEPTH     instruction memory depth in 32-bit words (power of two)
//   RESET_PC  byte address of the first fetch
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall          consumer cannot accept; everything except memory writes freezes
//   branch_taken   redirect to pc_out + 4 + (branch_offset << 2)
//   branch_offset  signed word offset of the branch
//   jump           redirect to {pc_out+4 [31:28], jump_index, 2'b00}; wins over branch
//   jump_index     jump instruction index field
//   prog_we        instruction memory write enable
//   prog_addr      instruction memory word address for writes
//   prog_data      instruction word to write
//   In             fetched instruction (32'h0 when not valid)
//   pc_out         byte address of the instruction on In
//   valid          In/pc_out hold a real instruction
//   halted         fetch stopped by a HALT opcode (cleared only by reset)
module instr_fetch #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [15:0]              branch_offset,
    input  logic                     jump,
    input  logic [25:0]              jump_index,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic [31:0]              In,
    output logic [31:0]              pc_out,
    output logic                     valid,
    output logic                     halted
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [5:0]  HALT_OP = 6'h3F;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] imem [DEPTH];

    logic [31:0] seq_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        halt_seen;

    // Redirect targets are relative to the instruction currently presented
    // (pc_out), not to the internal pc which already points one word ahead.
    always_comb begin
        seq_pc          = pc_out + 32'd4;
        branch_target   = seq_pc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jump_target     = {seq_pc[31:28], jump_index, 2'b00};
        redirect_target = jump ? jump_target : branch_target;
        redirect        = valid && (jump || branch_taken);
        halt_seen       = valid && (In[31:26] == HALT_OP);
    end

    // Memory has no reset so a program loaded before/under reset survives it.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // The read below samples imem before this edge's write lands, giving
    // read-first behaviour on a same-word write/fetch collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            In     <= '0;
            pc_out <= RESET_PC;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else if (!stall) begin
            unique case (state)
                // One idle edge after reset release; first fetch on the next.
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // Squash the wrong-path slot; target fetched next edge.
                        pc    <= redirect_target;
                        In    <= '0;
                        valid <= 1'b0;
                    end else if (halt_seen) begin
                        state  <= HALT;
                        In     <= '0;
                        valid  <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        In     <= imem[pc[AW+1:2]];
                        pc_out <= pc;
                        valid  <= 1'b1;
                        pc     <= pc + 32'd4;
                    end
                end
                HALT: begin
                    In     <= '0;
                    valid  <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
